io_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the non-cacheable IO bus driven by the gpgpu top level (io_write_en/io_read_en/io_address/io_write_data/io_read_data).
- Cores write bytes into a transmit FIFO; a serializer shifts them out as 8N1 frames on a single TX pin.
- Status and divisor registers are readable so software can poll for space before writing.

---
 rtl/io_uart_tx_pkg.sv | 27 ++
 rtl/io_uart_tx_sync_fifo.sv | 55 +++++
 rtl/io_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_io_uart_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package io_uart_tx_pkg;

  // Register offsets from the peripheral base address (word-spaced).
  localparam logic [31:0] UART_STATUS  = 32'h0000_0000;
  localparam logic [31:0] UART_TXDATA  = 32'h0000_0004;
  localparam logic [31:0] UART_DIVISOR = 32'h0000_0008;

  // STATUS register bit positions.
  localparam int STATUS_NOT_FULL_BIT  = 0;
  localparam int STATUS_BUSY_BIT      = 1;
  localparam int STATUS_OVERFLOW_BIT  = 2;
  localparam int STATUS_COUNT_LSB     = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of zero would stall the bit timer; run it as one clock per bit.
  function automatic logic [15:0] eff_divisor(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible combinationally on dout.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_enq;
  logic             do_deq;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign count  = count_q;
  assign dout   = mem_q[rd_ptr_q];
  assign do_deq = deq && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_enq = enq && (!full || do_deq);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, transmit FIFO and serializer FSM.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   offset;
  logic          sel_status;
  logic          sel_txdata;
  logic          sel_divisor;
  logic          push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          busy;
  logic [31:0]   status_w;

  logic [31:0]   read_data_q, read_data_d;
  logic [15:0]   divisor_q, divisor_d;
  logic          overflow_q, overflow_d;

  tx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   lat_div_q, lat_div_d;
  logic          cnt_done;

  logic          unused_wdata;
  assign unused_wdata = &{1'b0, io_write_data[31:16]};

  assign offset      = io_address - BASE_ADDRESS;
  assign sel_status  = (offset == UART_STATUS);
  assign sel_txdata  = (offset == UART_TXDATA);
  assign sel_divisor = (offset == UART_DIVISOR);
  assign push        = io_write_en && sel_txdata;
  assign busy        = !fifo_empty || (state_q != TX_IDLE);
  assign cnt_done    = (cnt_q == 16'd0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .enq   (push),
    .deq   (fifo_pop),
    .din   (io_write_data[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble the STATUS word from live state.
  always_comb begin
    status_w                      = '0;
    status_w[STATUS_NOT_FULL_BIT] = !fifo_full;
    status_w[STATUS_BUSY_BIT]     = busy;
    status_w[STATUS_OVERFLOW_BIT] = overflow_q;
    status_w[STATUS_COUNT_LSB +: CW] = fifo_count;
  end

  // Register-file next state: read mux, divisor write, sticky overflow (set beats clear).
  always_comb begin
    read_data_d = read_data_q;
    if (io_read_en) begin
      if (sel_status)       read_data_d = status_w;
      else if (sel_divisor) read_data_d = {16'h0000, divisor_q};
      else                  read_data_d = '0;
    end
    divisor_d = divisor_q;
    if (io_write_en && sel_divisor) divisor_d = io_write_data[15:0];
    overflow_d = overflow_q;
    if (push && fifo_full && !fifo_pop)  overflow_d = 1'b1;
    else if (io_read_en && sel_status)   overflow_d = 1'b0;
  end

  // Register-file state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
      divisor_q   <= DEFAULT_DIVISOR;
      overflow_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      divisor_q   <= divisor_d;
      overflow_q  <= overflow_d;
    end
  end

  assign io_read_data = read_data_q;

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      lat_div_q <= 16'd1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      lat_div_q <= lat_div_d;
    end
  end

  // Serializer next state: bit timer is a down-counter reloaded at each bit boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    lat_div_d = lat_div_q;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_d   = TX_START;
          shift_d   = fifo_head;
          lat_div_d = eff_divisor(divisor_q);
          cnt_d     = eff_divisor(divisor_q) - 16'd1;
          bit_idx_d = '0;
        end
      end
      TX_START: begin
        if (cnt_done) begin
          state_d   = TX_DATA;
          cnt_d     = lat_div_q - 16'd1;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt_done) begin
          cnt_d = lat_div_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt_done) state_d = TX_IDLE;
        else          cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Serializer outputs: line level and FIFO pop.
  always_comb begin
    uart_tx  = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE:  fifo_pop = !fifo_empty;
      TX_START: uart_tx  = 1'b0;
      TX_DATA:  uart_tx  = shift_q[0];
      TX_STOP:  uart_tx  = 1'b1;
      default:  uart_tx  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: line waveform compared against an ideal 8N1 frame model.
module tb_io_uart_tx;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = BASE + 32'h0;
  localparam logic [31:0] A_TX   = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_BAD  = BASE + 32'hC;
  localparam int          LOGN   = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [31:0] io_address = '0;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        uart_tx;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          tx_log [LOGN];
  bit          exp_q [$];

  io_uart_tx dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) tx_log[cyc] = uart_tx;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_address    = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    io_address = a;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic exp_ones(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  // Ideal 8N1 frame: start 0, data LSB first, stop 1; each bit held for the divisor (0 counts as 1).
  task automatic exp_frame(input logic [7:0] b, input int div);
    int d;
    bit bits [10];
    d = (div == 0) ? 1 : div;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = 1'b1;
    for (int i = 0; i < 10; i++) repeat (d) exp_q.push_back(bits[i]);
  endtask

  task automatic check_wave(input string tag, input int unsigned start);
    int unsigned n;
    int nerr;
    n = exp_q.size();
    nerr = 0;
    wait_until(start + n + 1);
    for (int unsigned i = 0; i < n; i++)
      if (tx_log[start+i] !== exp_q[i]) nerr++;
    check(tag, nerr, 0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b0, b1;
    logic [7:0]  burst [5];
    int unsigned c;
    int          div, n, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_rdata", io_read_data, 0);
    reset = 1'b1;
    @(negedge clk);
    rd(A_STAT, d);
    check("status_reset", d, 32'h1);
    rd(A_DIV, d);
    check("div_reset", d, 32'd27);
    repeat (3) @(negedge clk);
    check("rdata_hold", io_read_data, 32'd27);

    // 0x55 at divisor 4: latency, waveform and busy drop
    wr(A_DIV, 32'd4);
    wr(A_TX, 32'h55);
    c = cyc;
    wait_until(c + 40);
    rd(A_STAT, d);
    check("busy_last_stop", d, 32'h3);
    rd(A_STAT, d);
    check("busy_clear", d, 32'h1);
    exp_ones(1); exp_frame(8'h55, 4); exp_ones(1);
    check_wave("frame_55_div4", c);

    // Divisor 0 behaves as 1 clock per bit
    wr(A_DIV, 32'd0);
    rd(A_DIV, d);
    check("div_zero_rd", d, 32'd0);
    wr(A_TX, 32'hA5);
    c = cyc;
    exp_ones(1); exp_frame(8'hA5, 0); exp_ones(2);
    check_wave("frame_a5_div0", c);

    // Divisor change mid-frame only affects the queued frame
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    wr(A_DIV, 32'd4);
    wr(A_TX, {24'h0, b0});
    c = cyc;
    wr(A_TX, {24'h0, b1});
    wr(A_DIV, 32'd8);
    exp_ones(1); exp_frame(b0, 4); exp_ones(1); exp_frame(b1, 8); exp_ones(2);
    check_wave("div_change_midframe", c);
    rd(A_DIV, d);
    check("div_after_change", d, 32'd8);

    // Random single frames
    for (int i = 0; i < 6; i++) begin
      div = $urandom_range(1, 6);
      b0  = 8'($urandom);
      wr(A_DIV, div);
      wr(A_TX, {24'h0, b0});
      c = cyc;
      exp_ones(1); exp_frame(b0, div); exp_ones(1);
      check_wave("rand_frame", c);
    end

    // Random back-to-back burst: one idle cycle between frames
    div = $urandom_range(1, 3);
    n   = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) burst[i] = 8'($urandom);
    wr(A_DIV, div);
    wr(A_TX, {24'h0, burst[0]});
    c = cyc;
    for (int i = 1; i < n; i++) wr(A_TX, {24'h0, burst[i]});
    exp_ones(1);
    for (int i = 0; i < n; i++) begin
      exp_frame(burst[i], div);
      exp_ones(1);
    end
    check_wave("rand_burst", c);

    // FIFO occupancy with a slow line: the first byte leaves the FIFO at once
    wr(A_DIV, 32'd100);
    n = $urandom_range(2, 9);
    for (int i = 0; i < n; i++) wr(A_TX, i);
    cnt = n - 1;
    rd(A_STAT, d);
    check("status_count", d, (cnt << 8) | 32'h2 | ((cnt < 8) ? 32'h1 : 32'h0));
    pulse_reset();

    wr(A_DIV, 32'd100);
    for (int i = 0; i < 10; i++) wr(A_TX, i);
    rd(A_STAT, d);
    check("status_overflow", d, 32'h806);
    rd(A_STAT, d);
    check("overflow_cleared", d, 32'h802);
    pulse_reset();

    // Reset in the middle of data bits
    wr(A_DIV, 32'd4);
    wr(A_TX, 32'h00);
    c = cyc;
    wr(A_TX, 32'h81);
    wait_until(c + 15);
    check("tx_low_in_data", uart_tx, 0);
    reset = 1'b0;
    #1;
    check("rst_async_tx", uart_tx, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(A_STAT, d);
    check("status_after_rst", d, 32'h1);
    c = cyc;
    exp_ones(60);
    check_wave("no_frame_after_rst", c);

    // Unmapped address and register write masking
    rd(A_BAD, d);
    check("bad_addr_read", d, 32'h0);
    c = cyc;
    wr(A_BAD, 32'h0000_0003);
    rd(A_DIV, d);
    check("bad_write_div", d, 32'd27);
    rd(A_STAT, d);
    check("bad_write_status", d, 32'h1);
    exp_ones(20);
    check_wave("bad_write_line", c);
    wr(A_DIV, 32'hABCD_0005);
    rd(A_DIV, d);
    check("div_upper_ignored", d, 32'd5);

    // Simultaneous read and write: read sees the old value
    io_address    = A_DIV;
    io_write_data = 32'd9;
    io_write_en   = 1'b1;
    io_read_en    = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    check("rw_same_cycle_old", io_read_data, 32'd5);
    rd(A_DIV, d);
    check("rw_same_cycle_new", d, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
